// File: rtl/uart_rx_between_pkg.sv
// Shared types and constants for the 8N1 UART receiver
// with a 4-phase handshake output.
package uart_rx_between_pkg;

    localparam int CLKS_PER_BIT_DEF = 868;
    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_WAIT_ACK,
        HS_WAIT_REL
    } hs_state_t;

endpackage

// File: rtl/uart_rx_between_bit_timer.sv
// Down-counting bit timer: load a delay, tc is high
// while the count sits at zero.
module uart_rx_between_bit_timer
    import uart_rx_between_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int W = $clog2(CLKS_PER_BIT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/uart_rx_between.sv
// 8N1 UART receiver; each good byte is offered on t0..t7
// through a tsent/trecieve 4-phase handshake.
module uart_rx_between
    import uart_rx_between_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    input  logic enable,
    input  logic trecieve,
    output logic t0,
    output logic t1,
    output logic t2,
    output logic t3,
    output logic t4,
    output logic t5,
    output logic t6,
    output logic t7,
    output logic tsent,
    output logic frame_err,
    output logic overrun,
    output logic busy
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [W-1:0] FULL_LD = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] HALF_LD = W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    logic rx_meta;
    logic rx_s;
    rx_state_t state;
    rx_state_t state_nx;
    hs_state_t hs;
    hs_state_t hs_nx;
    logic tmr_load;
    logic [W-1:0] tmr_val;
    logic tc;
    logic [IW-1:0] bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] t_reg;
    logic data_smp;
    logic byte_ok;
    logic stop_bad;
    logic t_load;
    logic ov_set;

    uart_rx_between_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .W(W)
    ) u_timer (
        .clk(clk),
        .reset(reset),
        .load(tmr_load),
        .load_val(tmr_val),
        .tc(tc)
    );

    // Two-flop synchronizer; the line idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s <= rx_meta;
        end
    end

    // Receiver and handshake state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hs <= HS_IDLE;
        end else begin
            state <= state_nx;
            hs <= hs_nx;
        end
    end

    // Receiver next state, timer control and sample strobes.
    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val = FULL_LD;
        data_smp = 1'b0;
        byte_ok = 1'b0;
        stop_bad = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && !rx_s) begin
                    state_nx = START;
                    tmr_load = 1'b1;
                    tmr_val = HALF_LD;
                end
            end
            START: begin
                if (tc) begin
                    if (!rx_s) begin
                        state_nx = DATA;
                        tmr_load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            DATA: begin
                if (tc) begin
                    data_smp = 1'b1;
                    tmr_load = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_nx = STOP;
                    end
                end
            end
            STOP: begin
                if (tc) begin
                    state_nx = IDLE;
                    byte_ok = rx_s;
                    stop_bad = !rx_s;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Data bits land LSB first; the index clears while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx <= '0;
            shreg <= '0;
        end else if (state == IDLE) begin
            bit_idx <= '0;
        end else if (data_smp) begin
            shreg[bit_idx] <= rx_s;
            bit_idx <= bit_idx + 1'b1;
        end
    end

    // Handshake next state; a byte finishing while busy is dropped.
    always_comb begin
        hs_nx = hs;
        t_load = 1'b0;
        unique case (hs)
            HS_IDLE: begin
                if (byte_ok) begin
                    hs_nx = HS_WAIT_ACK;
                    t_load = 1'b1;
                end
            end
            HS_WAIT_ACK: begin
                if (trecieve) begin
                    hs_nx = HS_WAIT_REL;
                end
            end
            HS_WAIT_REL: begin
                if (!trecieve) begin
                    hs_nx = HS_IDLE;
                end
            end
            default: hs_nx = HS_IDLE;
        endcase
        ov_set = byte_ok && (hs != HS_IDLE);
    end

    // Holding register and one-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_reg <= '0;
            frame_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (t_load) begin
                t_reg <= shreg;
            end
            frame_err <= stop_bad;
            overrun <= ov_set;
        end
    end

    assign tsent = (hs == HS_WAIT_ACK);
    assign busy = (state != IDLE);
    assign {t7, t6, t5, t4, t3, t2, t1, t0} = t_reg;

endmodule

// File: tb/tb_uart_rx_between.sv
// Self-checking bench for uart_rx_between at 8 clocks
// per bit: table of frames plus handshake corner cases.
module tb_uart_rx_between;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx = 1'b1;
    logic enable = 1'b1;
    logic trecieve = 1'b0;
    logic t0, t1, t2, t3, t4, t5, t6, t7;
    logic tsent, frame_err, overrun, busy;
    logic [7:0] tbus;

    int vec_cnt = 0;
    int err_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int rise_cnt = 0;
    logic tsent_q = 1'b0;
    logic busy_q = 1'b0;
    logic busy_seen = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic stop;
        logic exp_valid;
        int exp_fe;
    } vec_t;

    vec_t vecs[5];

    assign tbus = {t7, t6, t5, t4, t3, t2, t1, t0};

    uart_rx_between #(.CLKS_PER_BIT(N)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .enable(enable),
        .trecieve(trecieve),
        .t0(t0),
        .t1(t1),
        .t2(t2),
        .t3(t3),
        .t4(t4),
        .t5(t5),
        .t6(t6),
        .t7(t7),
        .tsent(tsent),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Scoreboard side: pop an expected byte on each tsent rise.
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (tsent && !tsent_q) begin
                rise_cnt++;
                if (exp_q.size() == 0) begin
                    check("tsent_unexpected", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", {24'h0, tbus}, {24'h0, e});
                    check("tsent_latency",
                          {30'h0, busy_q, busy}, 32'h2);
                end
            end
        end
        if (busy) busy_seen = 1'b1;
        tsent_q = tsent;
        busy_q = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d,
                             input logic stop);
        rx = 1'b0;
        tick(N);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(N);
        end
        rx = stop;
        tick(N);
        rx = 1'b1;
    endtask

    task automatic ack();
        check("tsent_before_ack", {31'h0, tsent}, 1);
        trecieve = 1'b1;
        tick(1);
        check("tsent_drop", {31'h0, tsent}, 0);
        tick(4);
        check("tsent_no_reassert", {31'h0, tsent}, 0);
        trecieve = 1'b0;
        tick(3);
    endtask

    initial begin
        int fe0, ov0, r0;
        logic stable;
        logic [7:0] last_t;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 0};

        tick(3);
        check("reset_outputs",
              {20'h0, tsent, frame_err, overrun, busy, tbus}, 0);
        reset = 1'b1;
        tick(5);
        last_t = 8'h00;

        for (int i = 0; i < 5; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
            send_byte(vecs[i].data, vecs[i].stop);
            tick(3 * N);
            check("fe_count", fe_cnt - fe0, vecs[i].exp_fe);
            check("ov_count", ov_cnt - ov0, 0);
            check("tsent_state", {31'h0, tsent},
                  {31'h0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check("t_bits", {24'h0, tbus},
                      {24'h0, vecs[i].data});
                last_t = vecs[i].data;
                if (i == 0) begin
                    stable = 1'b1;
                    repeat (200) begin
                        @(negedge clk);
                        if (tsent !== 1'b1 || tbus !== 8'hA5)
                            stable = 1'b0;
                    end
                    tick(1);
                    check("hold_200", {31'h0, stable}, 1);
                end
                ack();
            end else begin
                check("t_hold_fe", {24'h0, tbus},
                      {24'h0, last_t});
            end
        end

        ov0 = ov_cnt;
        r0 = rise_cnt;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(3 * N);
        check("ovr_t_hold", {24'h0, tbus}, 32'h11);
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_rises", rise_cnt - r0, 1);
        ack();

        fe0 = fe_cnt;
        ov0 = ov_cnt;
        r0 = rise_cnt;
        busy_seen = 1'b0;
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(3 * N);
        check("glitch_start", {31'h0, busy_seen}, 1);
        check("glitch_idle", {31'h0, busy}, 0);
        check("glitch_flags",
              (fe_cnt - fe0) + (ov_cnt - ov0) + (rise_cnt - r0), 0);

        r0 = rise_cnt;
        busy_seen = 1'b0;
        enable = 1'b0;
        send_byte(8'h77, 1'b1);
        tick(2 * N);
        check("enable_block", {30'h0, busy_seen, 1'b0} |
              (rise_cnt - r0), 0);
        enable = 1'b1;
        tick(2);

        exp_q.push_back(8'h96);
        fork
            send_byte(8'h96, 1'b1);
            begin
                tick(2 * N);
                enable = 1'b0;
            end
        join
        tick(2 * N);
        check("enable_mid", {24'h0, tbus}, 32'h96);
        ack();
        enable = 1'b1;

        fe0 = fe_cnt;
        ov0 = ov_cnt;
        r0 = rise_cnt;
        rx = 1'b0;
        tick(N);
        rx = 1'b1;
        tick(3 * N);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async",
              {20'h0, tsent, frame_err, overrun, busy, tbus}, 0);
        tick(2);
        reset = 1'b1;
        tick(3 * N);
        check("reset_release",
              (fe_cnt - fe0) + (ov_cnt - ov0) + (rise_cnt - r0), 0);
        check("reset_busy", {31'h0, busy}, 0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        tick(2 * N);
        check("post_reset_t", {24'h0, tbus}, 32'h5A);
        ack();

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_between.md
UART_RX_BETWEEN -- requirements
Module: uart_rx_between

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868; clk cycles per serial bit (100 MHz / 115200). Legal range 4..65535.
REQ-002 clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 reset  input  1  reset is asynchronous and active-low.
REQ-004 rx  input  1  asynchronous serial line; idles high; 8N1 format, LSB first.
REQ-005 enable  input  1  when 1, start-bit detection is allowed; when 0, the receiver stays in IDLE.
REQ-006 trecieve  input  1  downstream acknowledge of the 4-phase handshake.
REQ-007 t0..t7  output  1 each  received data bits in arrival order (t0 = first data bit = byte LSB).
REQ-008 tsent  output  1  byte-valid request of the 4-phase handshake.
REQ-009 frame_err  output  1  one-cycle pulse when a stop bit samples 0.
REQ-010 overrun  output  1  one-cycle pulse when a completed byte is dropped because the holding register is occupied.
REQ-011 busy  output  1  1 while the receiver FSM is outside IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value (2-cycle input latency).
REQ-013 Receiver FSM states: IDLE, START, DATA, STOP.
REQ-014 IDLE -> START when enable=1 and synchronized rx=0; the bit counter clears.
REQ-015 START: after CLKS_PER_BIT/2 (integer division) cycles, re-sample; 0 -> DATA, 1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA: sample once every CLKS_PER_BIT cycles into shift register position 0..7 in order; after the 8th sample -> STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; 1 = valid byte, 0 = frame_err pulse, byte discarded; either case -> IDLE on the next cycle.
REQ-018 Bit counter width SHALL be clog2(CLKS_PER_BIT); the counter reloads on each sample, with no wrap-around beyond CLKS_PER_BIT-1.
REQ-019 Handshake FSM states: HS_IDLE, HS_WAIT_ACK, HS_WAIT_REL.
REQ-020 On a valid stop bit in HS_IDLE: t0..t7 load and tsent=1 on the next clk, with the FSM going to HS_WAIT_ACK.
REQ-021 HS_WAIT_ACK: tsent and t0..t7 held stable; on trecieve=1, tsent=0 on the next clk -> HS_WAIT_REL.
REQ-022 HS_WAIT_REL: on trecieve=0 -> HS_IDLE; tsent SHALL NOT reassert before this transition.
REQ-023 Valid stop bit while the handshake is not in HS_IDLE: byte dropped, overrun pulse, t0..t7 unchanged.
REQ-024 Reception continues independently of the handshake state.
REQ-025 enable deasserted mid-frame does not abort the frame; it only blocks the next start detection.
REQ-026 trecieve=1 while in HS_IDLE SHALL be ignored.

Reset
REQ-027 Asserting reset (0) SHALL immediately force: both FSMs to IDLE/HS_IDLE, tsent=0, t0..t7=0, frame_err=0, overrun=0, busy=0, sync flops=1, counters=0.
REQ-028 Reset mid-frame or mid-handshake discards the partial byte; no flag pulses on release.

Structure
REQ-029 Shared package: CLKS_PER_BIT default, receiver and handshake state encodings, DATA_BITS=8.
REQ-030 One sub-module: bit_timer (load/count/terminal-count pulse, parameterized by CLKS_PER_BIT).

Verification (CLKS_PER_BIT=8)
REQ-031 Send 0xA5 -> t0..t7=1,0,1,0,0,1,0,1; tsent=1 one clk after the stop sample; frame_err=0.
REQ-032 Hold trecieve=0 for 200 cycles after tsent -> tsent and data stable; then trecieve=1 -> tsent=0 next clk; trecieve=0 -> HS_IDLE.
REQ-033 Send 0x3C with stop bit forced 0 -> one frame_err pulse; tsent stays 0.
REQ-034 Send 0x11 then 0x22 without acknowledging -> t bits hold 0x11; one overrun pulse at the 0x22 stop sample.
REQ-035 2-cycle low glitch on rx -> START returns to IDLE; no tsent, no flags.
REQ-036 Assert reset during DATA of 0xFF -> all outputs 0 immediately; after release, 0x5A is received correctly.
